fmul_round_pack: RTL and testbench
==================================

Name: fmul_round_pack

Overview:
- Downstream stage of the FMUL single-precision multiplier.
- Consumes FMUL's unpacked result: sign, 8-bit exp, 24-bit frac where frac[23:1] is the mantissa and frac[0] is a guard bit, plus the error and overflow flags.
- Performs round-to-nearest-even on the guard bit, handles mantissa carry, zero and Inf/NaN, and packs an IEEE754 32-bit word.
- Two-stage valid/ready pipeline; also keeps saturating exception counters for the status path.

Parameters:
- CNT_W, 16, width of each saturating exception counter.
- QNAN, 32'h7FC00000, word emitted when the error flag is set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  FMUL result valid
- in_ready  out  1  stage can accept a result
- in_sign  in  1  FMUL sign
- in_exp  in  8  FMUL exponent (biased)
- in_frac  in  24  FMUL fraction; [23:1] mantissa, [0] guard
- in_error  in  1  FMUL invalid-operation flag
- in_overflow  in  1  FMUL overflow flag
- out_valid  out  1  packed result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  packed IEEE754 result
- out_overflow  out  1  overflow (input flag or rounding carry)
- out_inexact  out  1  guard bit discarded or rounded
- out_error  out  1  NaN result emitted
- cnt_clear  in  1  synchronous clear of all counters
- cnt_error  out  CNT_W  saturating count of emitted error results
- cnt_overflow  out  CNT_W  saturating count of emitted overflow results
- cnt_inexact  out  CNT_W  saturating count of emitted inexact results

Behaviour:
- Reset: all outputs 0 (out_valid=0, out_data=0, all flags 0, counters 0). Both stage valid bits clear. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards in-flight data; nothing is emitted afterwards.
- Handshake: a transfer occurs on a rising clk edge with valid&&ready. Inputs are sampled only on in_valid&&in_ready.
- While out_valid=1 and out_ready=0, out_* hold stable.
- Stage 1 (S1) registers the raw inputs.
- Stage 2 (S2) registers the packed result and flags; S2 drives out_*.
- Latency: 2 cycles from accepting transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- S2 loads when it is empty or out_ready=1.
- S1 advances when S2 loads.
- in_ready = !S1_valid || S2 loads. in_ready is combinational from out_ready; there is no combinational path from in_valid.
- Capacity is 2 entries; order is strictly preserved and no result is dropped or duplicated.
- Packing priority, evaluated in S2 from S1 contents:
  1. error=1: out_data=QNAN; out_error=1; other flags 0.
  2. overflow=1: out_data={sign,8'hFF,23'h0}; out_overflow=1; out_inexact=0.
  3. exp==8'hFF: out_data={sign,8'hFF,frac[23:1]}; no rounding; flags 0.
  4. exp==0: out_data={sign,31'h0} (flush-to-zero); out_inexact=|frac.
  5. Normal case: m=frac[23:1], g=frac[0]. round_up = g & m[0] (ties-to-even, no sticky). m'=m+round_up in 24 bits.
     - Carry (m'[23]=1): mantissa=0, exp+1.
     - exp+1 reaching 8'hFF: out_data={sign,8'hFF,23'h0}, out_overflow=1.
     - out_inexact=g.
- Counters: each increments by 1 on an output transfer (out_valid&&out_ready) whose corresponding flag is 1. Each saturates at all-ones with no wrap.
- cnt_clear zeroes all counters and wins over a same-cycle increment.

Test Plan:
- exp=8'h8D, frac=24'b11000010000000000000000_0, sign=0, no backpressure -> out_data=32'h46E10000 exactly 2 cycles after acceptance; inexact=0.
- Ties-to-even at exp=8'h80: frac=24'h000003 -> 32'h40000002 with inexact=1; frac=24'h000001 -> 32'h40000000 with inexact=1.
- Carry cases: exp=8'h80, frac=24'hFFFFFF -> 32'h40800000. exp=8'hFE, frac=24'hFFFFFF, sign=1 -> 32'hFF800000 with out_overflow=1 and cnt_overflow=1.
- Flag priority: error=1 and overflow=1 together -> 32'h7FC00000 with out_error=1 only. overflow=1, sign=0 -> 32'h7F800000. exp=0, frac=24'h000002 -> 32'h00000000 with inexact=1.
- Backpressure: hold out_ready=0 while presenting 3 back-to-back inputs -> in_ready drops after 2 acceptances and out_data stays stable. Release out_ready -> all 3 results emerge in order, one per cycle.
- Reset and counters: assert rst with 2 entries in flight -> next cycle out_valid=0 and counters 0. Force cnt_inexact to all-ones (CNT_W=4 build) -> it stays at 4'hF. cnt_clear coincident with an increment -> 0.

Source files
------------

// File: rtl/fmul_round_pack_if.sv
// Handshake/data bundle between FMUL, the round/pack stage and its consumer.
//   in_*  : unpacked FMUL result with valid/ready
//   out_* : packed IEEE754 word plus flags with valid/ready
// master : environment side (drives in_*, out_ready)
// slave  : round/pack stage side (drives in_ready, out_*)
interface fmul_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_frac;
  logic        in_error;
  logic        in_overflow;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_overflow;
  logic        out_inexact;
  logic        out_error;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_inexact, out_error
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_inexact, out_error
  );
endinterface

// File: rtl/fmul_round_pack.sv
// Round-to-nearest-even and IEEE754 packing stage behind the FMUL multiplier.
// Two-entry valid/ready pipeline: S1 registers the raw FMUL result, S2 registers
// the packed word and flags and drives the output side of the bus.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : in_* handshake from FMUL, out_* handshake to consumer
//   cnt_clear     : synchronous clear of the exception counters
//   cnt_error     : saturating count of emitted NaN results
//   cnt_overflow  : saturating count of emitted overflow results
//   cnt_inexact   : saturating count of emitted inexact results
module fmul_round_pack #(
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic                clk,
  input  logic                rst,
  fmul_round_pack_if.slave    bus,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    cnt_error,
  output logic [CNT_W-1:0]    cnt_overflow,
  output logic [CNT_W-1:0]    cnt_inexact
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // S1: raw FMUL result
  logic        s1_valid_q;
  logic        s1_sign_q;
  logic [7:0]  s1_exp_q;
  logic [23:0] s1_frac_q;
  logic        s1_error_q;
  logic        s1_overflow_q;

  // S2: packed result
  logic        s2_valid_q;
  logic [31:0] s2_data_q;
  logic        s2_overflow_q;
  logic        s2_inexact_q;
  logic        s2_error_q;

  logic [CNT_W-1:0] cnt_error_q, cnt_overflow_q, cnt_inexact_q;

  logic s2_load;
  logic in_fire;
  logic out_fire;

  assign s2_load  = !s2_valid_q || bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = s2_valid_q && bus.out_ready;

  assign bus.in_ready     = !s1_valid_q || s2_load;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_data     = s2_data_q;
  assign bus.out_overflow = s2_overflow_q;
  assign bus.out_inexact  = s2_inexact_q;
  assign bus.out_error    = s2_error_q;

  assign cnt_error    = cnt_error_q;
  assign cnt_overflow = cnt_overflow_q;
  assign cnt_inexact  = cnt_inexact_q;

  // Rounding datapath. Only the guard bit is available (no sticky), so a tie is
  // any set guard bit and ties go to the even mantissa.
  logic [22:0] mant;
  logic        guard;
  logic [23:0] mant_rnd;
  logic [7:0]  exp_inc;

  assign mant     = s1_frac_q[23:1];
  assign guard    = s1_frac_q[0];
  assign mant_rnd = {1'b0, mant} + {23'b0, guard & mant[0]};
  assign exp_inc  = s1_exp_q + 8'd1;

  logic [31:0] pk_data;
  logic        pk_overflow;
  logic        pk_inexact;
  logic        pk_error;

  always_comb begin
    pk_data     = 32'h0;
    pk_overflow = 1'b0;
    pk_inexact  = 1'b0;
    pk_error    = 1'b0;
    if (s1_error_q) begin
      pk_data  = QNAN;
      pk_error = 1'b1;
    end else if (s1_overflow_q) begin
      pk_data     = {s1_sign_q, 8'hFF, 23'h0};
      pk_overflow = 1'b1;
    end else if (s1_exp_q == 8'hFF) begin
      // Inf/NaN passes through unrounded
      pk_data = {s1_sign_q, 8'hFF, mant};
    end else if (s1_exp_q == 8'h00) begin
      // Flush-to-zero; anything nonzero was lost
      pk_data    = {s1_sign_q, 31'h0};
      pk_inexact = |s1_frac_q;
    end else begin
      pk_inexact = guard;
      if (mant_rnd[23]) begin
        // Mantissa carried out: renormalise, possibly into Inf
        if (exp_inc == 8'hFF) begin
          pk_data     = {s1_sign_q, 8'hFF, 23'h0};
          pk_overflow = 1'b1;
        end else begin
          pk_data = {s1_sign_q, exp_inc, 23'h0};
        end
      end else begin
        pk_data = {s1_sign_q, s1_exp_q, mant_rnd[22:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_exp_q       <= 8'h0;
      s1_frac_q      <= 24'h0;
      s1_error_q     <= 1'b0;
      s1_overflow_q  <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_data_q      <= 32'h0;
      s2_overflow_q  <= 1'b0;
      s2_inexact_q   <= 1'b0;
      s2_error_q     <= 1'b0;
      cnt_error_q    <= '0;
      cnt_overflow_q <= '0;
      cnt_inexact_q  <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q    <= 1'b1;
        s1_sign_q     <= bus.in_sign;
        s1_exp_q      <= bus.in_exp;
        s1_frac_q     <= bus.in_frac;
        s1_error_q    <= bus.in_error;
        s1_overflow_q <= bus.in_overflow;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q     <= pk_data;
          s2_overflow_q <= pk_overflow;
          s2_inexact_q  <= pk_inexact;
          s2_error_q    <= pk_error;
        end
      end

      // Clear takes priority over a same-cycle increment
      if (cnt_clear) begin
        cnt_error_q    <= '0;
        cnt_overflow_q <= '0;
        cnt_inexact_q  <= '0;
      end else if (out_fire) begin
        if (s2_error_q && cnt_error_q != CntMax) begin
          cnt_error_q <= cnt_error_q + CntOne;
        end
        if (s2_overflow_q && cnt_overflow_q != CntMax) begin
          cnt_overflow_q <= cnt_overflow_q + CntOne;
        end
        if (s2_inexact_q && cnt_inexact_q != CntMax) begin
          cnt_inexact_q <= cnt_inexact_q + CntOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_fmul_round_pack.sv
// Self-checking bench for fmul_round_pack: directed test-plan vectors, then a
// randomized phase, all checked against an arithmetic reference model and a
// queue-based pipeline occupancy model.
module tb_fmul_round_pack;

  localparam int CntMax = 15;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clear;
  logic [3:0] cnt_error, cnt_overflow, cnt_inexact;

  always #5 clk = ~clk;

  fmul_round_pack_if bus ();

  fmul_round_pack #(
    .CNT_W (4),
    .QNAN  (32'h7FC00000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cnt_clear    (cnt_clear),
    .cnt_error    (cnt_error),
    .cnt_overflow (cnt_overflow),
    .cnt_inexact  (cnt_inexact)
  );

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        inex;
    logic        err;
    int          acc;   // edge count at which the entry was accepted
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   m_cerr, m_covf, m_cinex;
  logic last_acc;

  logic        d_valid, d_sign, d_err, d_ovf, d_ready, d_clear, d_rst;
  logic [7:0]  d_exp;
  logic [23:0] d_frac;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: significand with hidden bit, doubled to hold the guard,
  // rounded half-to-even as an integer, then repacked.
  function automatic exp_t ref_pack(input logic s, input logic [7:0] e,
                                    input logic [23:0] f, input logic er, input logic ov);
    exp_t r;
    int unsigned sig, g, ex;
    logic [31:0] ew;
    r.data = 32'h0; r.ovf = 1'b0; r.inex = 1'b0; r.err = 1'b0; r.acc = 0;
    if (er) begin
      r.data = 32'h7FC00000;
      r.err  = 1'b1;
    end else if (ov) begin
      r.data = {s, 31'h7F800000};
      r.ovf  = 1'b1;
    end else if (e == 8'd255) begin
      r.data = {s, 8'hFF, 23'(f >> 1)};
    end else if (e == 8'd0) begin
      r.data = {s, 31'h0};
      r.inex = (f != 24'd0);
    end else begin
      sig = (32'd1 << 23) + 32'(f >> 1);
      g   = 32'(f) % 2;
      ex  = 32'(e);
      if (g == 1 && sig % 2 == 1) sig = sig + 1;
      if (sig == (32'd1 << 24)) begin
        sig = sig / 2;
        ex  = ex + 1;
      end
      r.inex = (g == 1);
      if (ex >= 255) begin
        r.data = {s, 31'h7F800000};
        r.ovf  = 1'b1;
      end else begin
        ew     = ex;
        r.data = {s, ew[7:0], 23'(sig - (32'd1 << 23))};
      end
    end
    return r;
  endfunction

  function automatic int sat_inc(input int v, input logic f);
    return (f && v < CntMax) ? v + 1 : v;
  endfunction

  // One clock cycle: drive, sample half a cycle before the edge, check, update model.
  task automatic step();
    int   n;
    logic exp_ov, exp_rdy, fire_out;
    @(negedge clk);
    rst           = d_rst;
    cnt_clear     = d_clear;
    bus.in_valid  = d_valid;
    bus.in_sign   = d_sign;
    bus.in_exp    = d_exp;
    bus.in_frac   = d_frac;
    bus.in_error  = d_err;
    bus.in_overflow = d_ovf;
    bus.out_ready = d_ready;
    #1;
    last_acc = 1'b0;
    if (!d_rst) begin
      n       = q.size();
      exp_rdy = (n < 2) || d_ready;
      exp_ov  = (n > 0) && (cyc >= q[0].acc + 1);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_flags", 32'({bus.out_error, bus.out_overflow, bus.out_inexact}),
            32'({q[0].err, q[0].ovf, q[0].inex}));
      end
      chk("cnt_error", 32'(cnt_error), 32'(m_cerr));
      chk("cnt_overflow", 32'(cnt_overflow), 32'(m_covf));
      chk("cnt_inexact", 32'(cnt_inexact), 32'(m_cinex));
      fire_out = exp_ov && d_ready;
      if (fire_out) begin
        m_cerr  = sat_inc(m_cerr, q[0].err);
        m_covf  = sat_inc(m_covf, q[0].ovf);
        m_cinex = sat_inc(m_cinex, q[0].inex);
        void'(q.pop_front());
      end
      if (d_clear) begin
        m_cerr = 0; m_covf = 0; m_cinex = 0;
      end
      if (d_valid && exp_rdy) begin
        exp_t r;
        r     = ref_pack(d_sign, d_exp, d_frac, d_err, d_ovf);
        r.acc = cyc + 1;
        q.push_back(r);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    if (d_rst) begin
      q.delete();
      m_cerr = 0; m_covf = 0; m_cinex = 0;
    end
  endtask

  // Present one input until accepted (bounded).
  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] f,
                      input logic er, input logic ov);
    int tries;
    d_valid = 1'b1; d_sign = s; d_exp = e; d_frac = f; d_err = er; d_ovf = ov;
    tries = 0;
    do begin
      step();
      tries++;
    end while (!last_acc && tries < 20);
    if (!last_acc) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
    d_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    d_valid = 1'b0;
    repeat (k) step();
  endtask

  initial begin
    d_valid = 0; d_sign = 0; d_exp = 0; d_frac = 0; d_err = 0; d_ovf = 0;
    d_ready = 1; d_clear = 0; d_rst = 1;
    m_cerr = 0; m_covf = 0; m_cinex = 0;
    rst = 1; cnt_clear = 0;
    bus.in_valid = 0; bus.in_sign = 0; bus.in_exp = 0; bus.in_frac = 0;
    bus.in_error = 0; bus.in_overflow = 0; bus.out_ready = 1;

    // Reset
    step(); step();
    d_rst = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_flags", 32'({bus.out_error, bus.out_overflow, bus.out_inexact}), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_counters", 32'({cnt_error, cnt_overflow, cnt_inexact}), 32'h0);

    // Directed test-plan vectors, no backpressure
    send(1'b0, 8'h8D, 24'b110000100000000000000000, 1'b0, 1'b0);
    idle(2);
    send(1'b0, 8'h80, 24'h000003, 1'b0, 1'b0);
    send(1'b0, 8'h80, 24'h000001, 1'b0, 1'b0);
    send(1'b0, 8'h80, 24'hFFFFFF, 1'b0, 1'b0);
    send(1'b1, 8'hFE, 24'hFFFFFF, 1'b0, 1'b0);
    idle(3);
    #1;
    chk("cnt_overflow_after_carry", 32'(cnt_overflow), 32'h1);
    send(1'b0, 8'h10, 24'h123456, 1'b1, 1'b1);
    send(1'b0, 8'h10, 24'h123456, 1'b0, 1'b1);
    send(1'b0, 8'h00, 24'h000002, 1'b0, 1'b0);
    send(1'b1, 8'hFF, 24'h400000, 1'b0, 1'b0);
    idle(3);

    // Backpressure: three back-to-back inputs, only two fit
    d_ready = 0;
    d_valid = 1; d_sign = 0; d_exp = 8'h81; d_frac = 24'h000011; d_err = 0; d_ovf = 0;
    step();
    d_exp = 8'h82; d_frac = 24'h000021;
    step();
    d_exp = 8'h83; d_frac = 24'h000031;
    step(); step();
    d_ready = 1;
    send(1'b0, 8'h83, 24'h000031, 1'b0, 1'b0);
    idle(4);

    // Saturate cnt_inexact
    repeat (17) send(1'b0, 8'h80, 24'h000001, 1'b0, 1'b0);
    idle(3);
    #1;
    chk("cnt_inexact_sat", 32'(cnt_inexact), 32'hF);

    // Clear coincident with an inexact output transfer
    send(1'b0, 8'h80, 24'h000001, 1'b0, 1'b0);
    idle(1);
    d_clear = 1;
    step();
    d_clear = 0;
    #1;
    chk("cnt_clear_wins", 32'(cnt_inexact), 32'h0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      d_valid = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      d_clear = ($urandom_range(0, 31) == 0);
      d_sign  = 1'($urandom);
      sel     = $urandom_range(0, 7);
      d_exp   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'hFE
              : 8'($urandom_range(1, 254));
      d_frac  = ($urandom_range(0, 5) == 0) ? 24'hFFFFFF : 24'($urandom);
      d_err   = ($urandom_range(0, 15) == 0);
      d_ovf   = ($urandom_range(0, 15) == 0);
      step();
    end
    d_clear = 0; d_ready = 1;
    idle(4);

    // Reset with two entries in flight
    d_ready = 0;
    send(1'b0, 8'h80, 24'h000001, 1'b0, 1'b1);
    send(1'b0, 8'h80, 24'h000003, 1'b1, 1'b0);
    d_rst = 1;
    step();
    d_rst = 0;
    d_ready = 1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_out_data", bus.out_data, 32'h0);
    chk("midrst_counters", 32'({cnt_error, cnt_overflow, cnt_inexact}), 32'h0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
